// File: rtl/uart_cfg_pkg.sv
// Shared encodings for the configurable UART: FSM state codes and parity_mode codes.
// parity_mode 2'b00 and 2'b11 both mean "no parity bit".
package uart_cfg_defs;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Tick indices within a 16-tick bit: start-bit midpoint and the last tick of one/two bits.
    localparam logic [4:0] TICK_MID   = 5'd7;
    localparam logic [4:0] TICK_LAST  = 5'd15;
    localparam logic [4:0] TICK_LAST2 = 5'd31;

    function automatic logic parity_on(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_cfg_fifo.sv
// Synchronous first-word fall-through FIFO with active-high async reset.
// Full: simultaneous read and write both succeed. Empty: simultaneous read and write performs only the write.
module fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic [DATA_W-1:0] w_data,
    output logic              empty,
    output logic              full,
    output logic [DATA_W-1:0] r_data
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [ADDR_W-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
    logic              full_q, full_d, empty_q, empty_d;
    logic              do_rd, do_wr;

    assign do_rd = rd & ~empty_q;
    assign do_wr = wr & (~full_q | do_rd);

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[w_ptr_q] <= w_data;
    end

    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        full_d  = full_q;
        empty_d = empty_q;
        if (do_wr) w_ptr_d = w_ptr_q + ADDR_W'(1);
        if (do_rd) r_ptr_d = r_ptr_q + ADDR_W'(1);
        if (do_wr && !do_rd) begin
            empty_d = 1'b0;
            full_d  = (w_ptr_d == r_ptr_q);
        end else if (do_rd && !do_wr) begin
            full_d  = 1'b0;
            empty_d = (r_ptr_d == w_ptr_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign empty  = empty_q;
    assign full   = full_q;
    assign r_data = mem_q[r_ptr_q];

endmodule

// File: rtl/uart_cfg.sv
// UART with runtime baud divisor, parity mode and stop-bit count, RX/TX FIFOs and sticky RX errors.
// dbg_rx_state / dbg_tx_state expose the FSM state codes from uart_cfg_defs.
module uart_cfg
    import uart_cfg_defs::*;
#(
    parameter int DBIT     = 8,
    parameter int FIFO_W   = 4,
    parameter int DVSR_BIT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DVSR_BIT-1:0] dvsr,
    input  logic [1:0]          parity_mode,
    input  logic                stop2,
    input  logic                rx,
    input  logic                rd_uart,
    input  logic                wr_uart,
    input  logic [DBIT-1:0]     w_data,
    input  logic                clr_err,
    output logic [DBIT-1:0]     r_data,
    output logic                rx_empty,
    output logic                rx_full,
    output logic                tx_empty,
    output logic                tx_full,
    output logic                tx,
    output logic                tx_busy,
    output logic                parity_err,
    output logic                frame_err,
    output logic                overrun_err,
    output logic [2:0]          dbg_rx_state,
    output logic [2:0]          dbg_tx_state
);

    logic [DVSR_BIT-1:0] baud_cnt_q, baud_cnt_d, dvsr_q, dvsr_d;
    logic                tick;

    // Divisor is re-latched only at wrap so a mid-period change never shortens a tick.
    assign tick = (baud_cnt_q == dvsr_q);
    always_comb begin
        baud_cnt_d = tick ? '0 : baud_cnt_q + DVSR_BIT'(1);
        dvsr_d     = tick ? dvsr : dvsr_q;
    end

    logic [1:0]      rx_sync_q;
    logic            rx_s, rx_prev_q;
    logic [2:0]      rx_state_q, rx_state_d;
    logic [4:0]      rx_s_q, rx_s_d;
    logic [3:0]      rx_n_q, rx_n_d;
    logic [DBIT-1:0] rx_shift_q, rx_shift_d;
    logic [1:0]      rx_pmode_q, rx_pmode_d;
    logic            rx_stop2_q, rx_stop2_d, rx_done_q, rx_done_d;
    logic            par_evt, frm_evt, ovr_evt;

    assign rx_s = rx_sync_q[1];

    always_comb begin
        rx_state_d = rx_state_q;
        rx_s_d     = rx_s_q;
        rx_n_d     = rx_n_q;
        rx_shift_d = rx_shift_q;
        rx_pmode_d = rx_pmode_q;
        rx_stop2_d = rx_stop2_q;
        rx_done_d  = 1'b0;
        par_evt    = 1'b0;
        frm_evt    = 1'b0;
        case (rx_state_q)
            ST_IDLE: if (rx_prev_q && !rx_s) begin
                rx_state_d = ST_START;
                rx_s_d     = '0;
                rx_pmode_d = parity_mode;
                rx_stop2_d = stop2;
            end
            ST_START: if (tick) begin
                if (rx_s_q == TICK_MID) begin
                    rx_s_d     = '0;
                    rx_n_d     = '0;
                    rx_state_d = rx_s ? ST_IDLE : ST_DATA;
                end else rx_s_d = rx_s_q + 5'd1;
            end
            ST_DATA: if (tick) begin
                if (rx_s_q == TICK_LAST) begin
                    rx_s_d     = '0;
                    rx_shift_d = {rx_s, rx_shift_q[DBIT-1:1]};
                    if (rx_n_q == 4'(DBIT - 1))
                        rx_state_d = parity_on(rx_pmode_q) ? ST_PARITY : ST_STOP;
                    else
                        rx_n_d = rx_n_q + 4'd1;
                end else rx_s_d = rx_s_q + 5'd1;
            end
            ST_PARITY: if (tick) begin
                if (rx_s_q == TICK_LAST) begin
                    rx_s_d     = '0;
                    par_evt    = rx_s ^ (^rx_shift_q) ^ (rx_pmode_q == PAR_ODD);
                    rx_state_d = ST_STOP;
                end else rx_s_d = rx_s_q + 5'd1;
            end
            ST_STOP: if (tick) begin
                rx_s_d = rx_s_q + 5'd1;
                if (rx_s_q == TICK_LAST || rx_s_q == TICK_LAST2) begin
                    if (!rx_s) frm_evt = 1'b1;
                    if (rx_s_q == TICK_LAST2 || !rx_stop2_q) begin
                        rx_state_d = ST_IDLE;
                        rx_done_d  = 1'b1;
                    end
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    assign ovr_evt = rx_done_q & rx_full & ~rd_uart;

    logic [2:0]      tx_state_q, tx_state_d;
    logic [4:0]      tx_s_q, tx_s_d;
    logic [3:0]      tx_n_q, tx_n_d;
    logic [DBIT-1:0] tx_shift_q, tx_shift_d, tx_fifo_data;
    logic            tx_pen_q, tx_pen_d, tx_par_q, tx_par_d, tx_stop2_q, tx_stop2_d;
    logic            tx_q, tx_d, tx_busy_q, tx_pop;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_s_d     = tx_s_q;
        tx_n_d     = tx_n_q;
        tx_shift_d = tx_shift_q;
        tx_pen_d   = tx_pen_q;
        tx_par_d   = tx_par_q;
        tx_stop2_d = tx_stop2_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            ST_IDLE: if (tick && !tx_empty) tx_pop = 1'b1;
            ST_START: if (tick) begin
                if (tx_s_q == TICK_LAST) begin
                    tx_s_d     = '0;
                    tx_n_d     = '0;
                    tx_state_d = ST_DATA;
                end else tx_s_d = tx_s_q + 5'd1;
            end
            ST_DATA: if (tick) begin
                if (tx_s_q == TICK_LAST) begin
                    tx_s_d     = '0;
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_n_q == 4'(DBIT - 1)) tx_state_d = tx_pen_q ? ST_PARITY : ST_STOP;
                    else                        tx_n_d = tx_n_q + 4'd1;
                end else tx_s_d = tx_s_q + 5'd1;
            end
            ST_PARITY: if (tick) begin
                if (tx_s_q == TICK_LAST) begin
                    tx_s_d     = '0;
                    tx_state_d = ST_STOP;
                end else tx_s_d = tx_s_q + 5'd1;
            end
            ST_STOP: if (tick) begin
                if (tx_s_q == (tx_stop2_q ? TICK_LAST2 : TICK_LAST)) begin
                    if (!tx_empty) tx_pop = 1'b1;
                    else           tx_state_d = ST_IDLE;
                end else tx_s_d = tx_s_q + 5'd1;
            end
            default: tx_state_d = ST_IDLE;
        endcase
        // A pop (from IDLE or straight out of STOP) loads the frame and its latched settings.
        if (tx_pop) begin
            tx_state_d = ST_START;
            tx_s_d     = '0;
            tx_shift_d = tx_fifo_data;
            tx_pen_d   = parity_on(parity_mode);
            tx_par_d   = (^tx_fifo_data) ^ (parity_mode == PAR_ODD);
            tx_stop2_d = stop2;
        end
        case (tx_state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = tx_shift_d[0];
            ST_PARITY: tx_d = tx_par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_cnt_q  <= '0;
            dvsr_q      <= '0;
            rx_sync_q   <= 2'b00;
            rx_prev_q   <= 1'b0;
            rx_state_q  <= ST_IDLE;
            rx_s_q      <= '0;
            rx_n_q      <= '0;
            rx_shift_q  <= '0;
            rx_pmode_q  <= '0;
            rx_stop2_q  <= 1'b0;
            rx_done_q   <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            tx_state_q  <= ST_IDLE;
            tx_s_q      <= '0;
            tx_n_q      <= '0;
            tx_shift_q  <= '0;
            tx_pen_q    <= 1'b0;
            tx_par_q    <= 1'b0;
            tx_stop2_q  <= 1'b0;
            tx_q        <= 1'b1;
            tx_busy_q   <= 1'b0;
        end else begin
            baud_cnt_q  <= baud_cnt_d;
            dvsr_q      <= dvsr_d;
            rx_sync_q   <= {rx_sync_q[0], rx};
            rx_prev_q   <= rx_s;
            rx_state_q  <= rx_state_d;
            rx_s_q      <= rx_s_d;
            rx_n_q      <= rx_n_d;
            rx_shift_q  <= rx_shift_d;
            rx_pmode_q  <= rx_pmode_d;
            rx_stop2_q  <= rx_stop2_d;
            rx_done_q   <= rx_done_d;
            parity_err  <= (parity_err & ~clr_err) | par_evt;
            frame_err   <= (frame_err & ~clr_err) | frm_evt;
            overrun_err <= (overrun_err & ~clr_err) | ovr_evt;
            tx_state_q  <= tx_state_d;
            tx_s_q      <= tx_s_d;
            tx_n_q      <= tx_n_d;
            tx_shift_q  <= tx_shift_d;
            tx_pen_q    <= tx_pen_d;
            tx_par_q    <= tx_par_d;
            tx_stop2_q  <= tx_stop2_d;
            tx_q        <= tx_d;
            tx_busy_q   <= (tx_state_d != ST_IDLE);
        end
    end

    fifo #(.DATA_W(DBIT), .ADDR_W(FIFO_W)) u_rx_fifo (
        .clk(clk), .reset(~reset), .rd(rd_uart), .wr(rx_done_q), .w_data(rx_shift_q),
        .empty(rx_empty), .full(rx_full), .r_data(r_data)
    );

    fifo #(.DATA_W(DBIT), .ADDR_W(FIFO_W)) u_tx_fifo (
        .clk(clk), .reset(~reset), .rd(tx_pop), .wr(wr_uart), .w_data(w_data),
        .empty(tx_empty), .full(tx_full), .r_data(tx_fifo_data)
    );

    assign tx           = tx_q;
    assign tx_busy      = tx_busy_q;
    assign dbg_rx_state = rx_state_q;
    assign dbg_tx_state = tx_state_q;

endmodule

// File: tb/tb_uart_cfg.sv
// Self-checking bench for uart_cfg: frame timing, loopback, parity/frame/overrun errors, glitch and reset.
module tb_uart_cfg;
    import uart_cfg_defs::*;

    localparam int DBIT     = 8;
    localparam int FIFO_W   = 2;
    localparam int DVSR_BIT = 16;
    localparam int BIT_CLKS = 64;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [DVSR_BIT-1:0] dvsr = 16'd3;
    logic [1:0]          parity_mode = 2'b00;
    logic                stop2 = 1'b0;
    logic                rx;
    logic                rx_drv = 1'b1;
    logic                loop_en = 1'b0;
    logic                rd_uart = 1'b0;
    logic                wr_uart = 1'b0;
    logic [DBIT-1:0]     w_data = '0;
    logic                clr_err = 1'b0;
    logic [DBIT-1:0]     r_data;
    logic                rx_empty, rx_full, tx_empty, tx_full, tx, tx_busy;
    logic                parity_err, frame_err, overrun_err;
    logic [2:0]          dbg_rx_state, dbg_tx_state;

    int checks = 0;
    int errors = 0;
    logic [DBIT-1:0] exp_q[$];

    assign rx = loop_en ? tx : rx_drv;

    uart_cfg #(.DBIT(DBIT), .FIFO_W(FIFO_W), .DVSR_BIT(DVSR_BIT)) dut (
        .clk(clk), .reset(reset), .dvsr(dvsr), .parity_mode(parity_mode), .stop2(stop2),
        .rx(rx), .rd_uart(rd_uart), .wr_uart(wr_uart), .w_data(w_data), .clr_err(clr_err),
        .r_data(r_data), .rx_empty(rx_empty), .rx_full(rx_full), .tx_empty(tx_empty),
        .tx_full(tx_full), .tx(tx), .tx_busy(tx_busy), .parity_err(parity_err),
        .frame_err(frame_err), .overrun_err(overrun_err),
        .dbg_rx_state(dbg_rx_state), .dbg_tx_state(dbg_tx_state)
    );

    always #5 clk = ~clk;

    initial begin
        #600_000;
        $display("FAIL watchdog sim time exceeded CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input logic [DBIT-1:0] d);
        wr_uart = 1'b1;
        w_data  = d;
        @(negedge clk);
        wr_uart = 1'b0;
    endtask

    task automatic pulse_rd();
        rd_uart = 1'b1;
        @(negedge clk);
        rd_uart = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    // Drives one serial frame on rx; a low stop bit is released early so no fresh falling edge follows it.
    task automatic send_frame(input logic [DBIT-1:0] d, input logic par_en, input logic par_val,
                              input logic stop_low);
        rx_drv = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < DBIT; i++) begin
            rx_drv = d[i];
            wait_clks(BIT_CLKS);
        end
        if (par_en) begin
            rx_drv = par_val;
            wait_clks(BIT_CLKS);
        end
        if (stop_low) begin
            rx_drv = 1'b0;
            wait_clks(40);
            rx_drv = 1'b1;
            wait_clks(BIT_CLKS - 40);
        end else begin
            rx_drv = 1'b1;
            wait_clks(BIT_CLKS);
        end
    endtask

    task automatic wait_rx_word(input int budget, output bit ok);
        int t = 0;
        while (rx_empty && t < budget) begin
            @(negedge clk);
            t++;
        end
        ok = !rx_empty;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        wait_clks(3);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", tx_busy); end
        checks++; if ({parity_err, frame_err, overrun_err} !== 3'b000) begin
            errors++; $display("FAIL reset_errs got %b want 000", {parity_err, frame_err, overrun_err});
        end
        checks++; if ({rx_empty, rx_full, tx_empty, tx_full} !== 4'b1010) begin
            errors++; $display("FAIL reset_fifo got %b want 1010", {rx_empty, rx_full, tx_empty, tx_full});
        end
        checks++; if ({dbg_rx_state, dbg_tx_state} !== {ST_IDLE, ST_IDLE}) begin
            errors++; $display("FAIL reset_state got %h/%h want idle", dbg_rx_state, dbg_tx_state);
        end
        reset = 1'b1;
        wait_clks(5);
    endtask

    task automatic test_tx_frame();
        logic [9:0] fr;
        int t, cnt, bad;
        dvsr = 16'd3; parity_mode = 2'b00; stop2 = 1'b0; loop_en = 1'b0; rx_drv = 1'b1;
        fr = {1'b1, 8'hA5, 1'b0};
        wait_clks(8);
        push_tx(8'hA5);
        t = 0;
        while (!tx_busy && t < 200) begin @(negedge clk); t++; end
        checks++;
        if (!tx_busy) begin
            errors++; $display("FAIL tx_start_timeout got busy %b want 1", tx_busy);
        end else begin
            cnt = 0; bad = 0;
            while (tx_busy && cnt < 2000) begin
                if (cnt < 10 * BIT_CLKS && tx !== fr[cnt / BIT_CLKS]) bad++;
                cnt++;
                @(negedge clk);
            end
            checks++; if (cnt != 10 * BIT_CLKS) begin errors++; $display("FAIL tx_busy_len got %0d want %0d", cnt, 10 * BIT_CLKS); end
            checks++; if (bad != 0) begin errors++; $display("FAIL tx_bits got %0d wrong clocks want 0", bad); end
        end
        checks++; if (tx !== 1'b1 || tx_empty !== 1'b1) begin
            errors++; $display("FAIL tx_after got tx %b empty %b want 1 1", tx, tx_empty);
        end
    endtask

    task automatic test_loopback();
        logic [DBIT-1:0] vals [3];
        logic [DBIT-1:0] e;
        bit ok;
        int t;
        vals[0] = 8'h00; vals[1] = 8'hFF; vals[2] = 8'h3C;
        parity_mode = 2'b01; stop2 = 1'b1; loop_en = 1'b1;
        wait_clks(4);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(vals[i]);
            push_tx(vals[i]);
        end
        for (int i = 0; i < 3; i++) begin
            wait_rx_word(4000, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok) begin
                errors++; $display("FAIL loop_word%0d timeout got empty want %h", i, e);
            end else if (r_data !== e) begin
                errors++; $display("FAIL loop_word%0d got %h want %h", i, r_data, e);
            end
            if (ok) pulse_rd();
        end
        t = 0;
        while (tx_busy && t < 3000) begin @(negedge clk); t++; end
        wait_clks(BIT_CLKS);
        checks++; if ({parity_err, frame_err, overrun_err} !== 3'b000) begin
            errors++; $display("FAIL loop_errs got %b want 000", {parity_err, frame_err, overrun_err});
        end
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL loop_drained got %b want 1", rx_empty); end
        loop_en = 1'b0;
    endtask

    task automatic test_parity_err();
        logic [DBIT-1:0] e;
        parity_mode = 2'b01; stop2 = 1'b0; rx_drv = 1'b1;
        wait_clks(10);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, ~(^8'h5A), 1'b0);
        wait_clks(20);
        checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL par_err_set got %b want 1", parity_err); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL par_no_frame got %b want 0", frame_err); end
        e = exp_q.pop_front();
        checks++; if (rx_empty !== 1'b0 || r_data !== e) begin
            errors++; $display("FAIL par_word got empty %b data %h want 0 %h", rx_empty, r_data, e);
        end
        pulse_rd();
        pulse_clr();
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL par_err_clr got %b want 0", parity_err); end
        parity_mode = 2'b10;
        exp_q.push_back(8'h31);
        send_frame(8'h31, 1'b1, ~(^8'h31), 1'b0);
        wait_clks(20);
        e = exp_q.pop_front();
        checks++; if (parity_err !== 1'b0 || rx_empty !== 1'b0 || r_data !== e) begin
            errors++; $display("FAIL par_odd_ok got err %b empty %b data %h want 0 0 %h", parity_err, rx_empty, r_data, e);
        end
        pulse_rd();
    endtask

    task automatic test_frame_err();
        logic [DBIT-1:0] e;
        parity_mode = 2'b00; stop2 = 1'b0;
        wait_clks(10);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        wait_clks(100);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL frame_err_set got %b want 1", frame_err); end
        e = exp_q.pop_front();
        checks++; if (rx_empty !== 1'b0 || r_data !== e) begin
            errors++; $display("FAIL frame_word got empty %b data %h want 0 %h", rx_empty, r_data, e);
        end
        pulse_rd();
        pulse_clr();
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL frame_err_clr got %b want 0", frame_err); end
        rx_drv = 1'b0;
        wait_clks(3);
        rx_drv = 1'b1;
        wait_clks(200);
        checks++; if (rx_empty !== 1'b1 || dbg_rx_state !== ST_IDLE) begin
            errors++; $display("FAIL glitch got empty %b state %h want 1 %h", rx_empty, dbg_rx_state, ST_IDLE);
        end
    endtask

    task automatic test_overrun();
        logic [DBIT-1:0] d, e;
        parity_mode = 2'b00; stop2 = 1'b0;
        wait_clks(10);
        for (int i = 0; i < 5; i++) begin
            d = DBIT'($urandom_range(0, 255));
            if (i < 4) exp_q.push_back(d);
            send_frame(d, 1'b0, 1'b0, 1'b0);
        end
        wait_clks(50);
        checks++; if (overrun_err !== 1'b1) begin errors++; $display("FAIL ovr_set got %b want 1", overrun_err); end
        checks++; if (rx_full !== 1'b1) begin errors++; $display("FAIL ovr_full got %b want 1", rx_full); end
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            checks++; if (rx_empty !== 1'b0 || r_data !== e) begin
                errors++; $display("FAIL ovr_word%0d got empty %b data %h want 0 %h", i, rx_empty, r_data, e);
            end
            pulse_rd();
        end
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL ovr_drained got %b want 1", rx_empty); end
        pulse_clr();
    endtask

    task automatic test_reset_mid_tx();
        int t, bad;
        parity_mode = 2'b00; stop2 = 1'b0; loop_en = 1'b0; rx_drv = 1'b1;
        wait_clks(10);
        push_tx(8'h5A);
        push_tx(8'h00);
        push_tx(8'h7E);
        t = 0;
        while (!tx_busy && t < 200) begin @(negedge clk); t++; end
        checks++;
        if (!tx_busy) begin
            errors++; $display("FAIL rst_start_timeout got busy %b want 1", tx_busy);
        end
        wait_clks(10 * BIT_CLKS + 5 * BIT_CLKS);
        checks++; if (tx !== 1'b0 || tx_busy !== 1'b1) begin
            errors++; $display("FAIL rst_midframe got tx %b busy %b want 0 1", tx, tx_busy);
        end
        reset = 1'b0;
        #1;
        checks++; if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_empty !== 1'b1) begin
            errors++; $display("FAIL rst_async got tx %b busy %b empty %b want 1 0 1", tx, tx_busy, tx_empty);
        end
        wait_clks(5);
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rst_quiet got %0d active clocks want 0", bad); end
        checks++; if (tx_empty !== 1'b1 || rx_empty !== 1'b1) begin
            errors++; $display("FAIL rst_fifos got tx_empty %b rx_empty %b want 1 1", tx_empty, rx_empty);
        end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_loopback();
        test_parity_err();
        test_frame_err();
        test_overrun();
        test_reset_mid_tx();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
